rr_sel_sequencer: RTL and testbench

//   Round-robin sequencer directly upstream of the 2-to-4 enable decoder.
//   - Arbitrates 4 request lines and drives the decoder's 2-bit select (sel) and enable (en).
//   - Holds each grant until the owner signals done.
//   - Guarantees one en-low cycle between grants, so the decoded one-hot output passes through 4'b0000.

---
 rtl/seq_pkg.sv | 17 +
 rtl/rr_sel_sequencer_pick.sv | 33 +++
 rtl/rr_sel_sequencer.sv | 157 +++++++++++++++
 tb/tb_rr_sel_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the round-robin select sequencer.
//   state_t : FSM encoding (IDLE / GRANT / RELEASE); the fourth code is illegal
//             and is steered back to IDLE by the top-level FSM.
//   NUM_CH  : number of request channels (one per decoder output).
//   SEL_W   : width of the decoder select bus.
package seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_sel_sequencer_pick.sv
// rr_pick: combinational rotating-priority search.
// Ports:
//   req [3:0] in   request lines
//   ptr [1:0] in   highest-priority index this round
//   any       out  at least one request is pending
//   idx [1:0] out  first requesting index in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//                  (equals ptr when nothing is requested)
module rr_pick
  import seq_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              any,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] cand;

  // Walk the offsets from furthest to nearest so the closest requester to
  // ptr is the last one written and therefore wins. The 2-bit add wraps 3->0.
  always_comb begin
    any  = |req;
    idx  = ptr;
    cand = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_sequencer.sv
// rr_sel_sequencer: round-robin sequencer feeding a 2-to-4 enable decoder.
// Grants one of four requesters at a time, holds the grant until the owner
// signals done, and forces one en-low cycle between grants so the decoded
// one-hot output always passes through 4'b0000.
//
// Optional build macro SEL_TIMEOUT_EN: adds a hold counter that force-releases
// a grant after HOLD_MAX cycles and pulses timeout. Without it the grant is
// held until done and timeout is tied low. The port list is the same in both.
//
// Parameters:
//   HOLD_MAX  max cycles a grant stays asserted (timeout build); 2..2**CNT_W
//   CNT_W     hold-counter width
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   req[3:0] in   request per channel
//   done     in   owner finished (only looked at in GRANT)
//   sel[1:0] out  decoder select (registered)
//   en       out  decoder enable, high only in GRANT (registered)
//   busy     out  state != IDLE (registered)
//   timeout  out  one-cycle pulse on forced release
module rr_sel_sequencer
  import seq_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic [SEL_W-1:0]  sel,
  output logic              en,
  output logic              busy,
  output logic              timeout
);

  // Reject configurations where the counter cannot reach HOLD_MAX-1.
  generate
    if (HOLD_MAX < 2 || (2 ** CNT_W) < HOLD_MAX) begin : g_bad_cfg
      $error("rr_sel_sequencer: HOLD_MAX must be in 2..2**CNT_W");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             en_nxt;
  logic             busy_nxt;
  logic             grant_start;
  logic             any;
  logic [SEL_W-1:0] idx;

`ifdef SEL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hold_expired;
  logic             timeout_nxt;
`endif

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (any),
    .idx (idx)
  );

  // State register plus the registered outputs, pointer and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
`ifdef SEL_TIMEOUT_EN
      cnt     <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      en    <= en_nxt;
      busy  <= busy_nxt;
`ifdef SEL_TIMEOUT_EN
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
`endif
    end
  end

  // Next-state logic. IDLE and RELEASE share arbitration; the only
  // difference is that RELEASE always leaves (to GRANT or IDLE).
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    grant_start = 1'b0;
`ifdef SEL_TIMEOUT_EN
    cnt_nxt      = cnt;
    hold_expired = 1'b0;
`endif
    case (state)
      IDLE, RELEASE: begin
        state_nxt = IDLE;
        if (any) begin
          state_nxt   = GRANT;
          grant_start = 1'b1;
          ptr_nxt     = idx + SEL_W'(1);
`ifdef SEL_TIMEOUT_EN
          cnt_nxt     = '0;
`endif
        end
      end
      GRANT: begin
        // req is deliberately not looked at here: the owner keeps the
        // grant even if it drops its request.
`ifdef SEL_TIMEOUT_EN
        cnt_nxt = cnt + CNT_W'(1);
        if (done) begin
          state_nxt = RELEASE;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = RELEASE;
          hold_expired = 1'b1;
        end
`else
        if (done) begin
          state_nxt = RELEASE;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs. sel only changes
  // when a new grant starts, so it keeps the last owner through RELEASE/IDLE.
  always_comb begin
    sel_nxt  = grant_start ? idx : sel;
    en_nxt   = (state_nxt == GRANT);
    busy_nxt = (state_nxt != IDLE);
`ifdef SEL_TIMEOUT_EN
    timeout_nxt = hold_expired;
`endif
  end

`ifndef SEL_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_sel_sequencer.sv
// Self-checking bench for rr_sel_sequencer: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_rr_sel_sequencer;

`ifdef SEL_TIMEOUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 16;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       en;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the decoder, whether we are in the enforced
  // gap, how long the owner has held it and whose turn is next.
  logic [1:0] m_sel;
  logic       m_en;
  logic       m_busy;
  logic       m_timeout;
  int         m_ptr;
  int         m_hold;

  always #5 clk = ~clk;

  rr_sel_sequencer #(
    .HOLD_MAX (HOLD),
    .CNT_W    (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .en      (en),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_sel = 2'b00; m_en = 1'b0; m_busy = 1'b0; m_timeout = 1'b0;
    m_ptr = 0; m_hold = 0;
  endtask

  // Advance the model across one rising edge with the inputs seen there.
  task automatic model_step(input logic [3:0] r, input logic d);
    int  w;
    logic forced;
    m_timeout = 1'b0;
    if (m_en) begin
      m_hold++;
      forced = 1'b0;
`ifdef SEL_TIMEOUT_EN
      forced = !d && (m_hold == HOLD);
`endif
      if (d || forced) begin
        m_en      = 1'b0;
        m_timeout = forced;
      end
    end else begin
      w = rr_winner(r, m_ptr);
      if (w >= 0) begin
        m_en   = 1'b1;
        m_busy = 1'b1;
        m_sel  = w[1:0];
        m_ptr  = (w + 1) % 4;
        m_hold = 0;
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("sel", sel, m_sel);
    check_eq("en", en, m_en);
    check_eq("busy", busy, m_busy);
    check_eq("timeout", timeout, m_timeout);
  endtask

  // Check at the falling edge, then drive the inputs for the next rising edge.
  task automatic cycle(input logic [3:0] r, input logic d);
    @(negedge clk);
    check_outputs();
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
  endtask

  // Asynchronous reset landing between edges; outputs must drop at once.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_en", en, 1'b0);
    check_eq("rst_sel", sel, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_timeout", timeout, 1'b0);
    model_reset();
    req  = 4'b0000;
    done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [1:0] rot [5];

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Single request: 0100 -> sel=10, en=1 one edge later.
    cycle(4'b0100, 1'b0);
    #1;
    check_eq("single_sel", sel, 2'b10);
    check_eq("single_en", en, 1'b1);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    #1;
    check_eq("single_idle_busy", busy, 1'b0);

    // Rotation from a fresh pointer with all four requesting.
    async_reset();
    cycle(4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      rot[i] = sel;
      check_eq("rot_en_hi", en, 1'b1);
      cycle(4'b1111, 1'b1);
      #1;
      check_eq("rot_gap", en, 1'b0);
      cycle(4'b1111, 1'b0);
    end
    check_eq("rot0", rot[0], 2'b00);
    check_eq("rot1", rot[1], 2'b01);
    check_eq("rot2", rot[2], 2'b10);
    check_eq("rot3", rot[3], 2'b11);
    check_eq("rot4", rot[4], 2'b00);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // Wrap/skip: get ptr to 3, then 0011 -> 00 then 01.
    async_reset();
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    cycle(4'b0011, 1'b0);
    #1;
    check_eq("wrap_first", sel, 2'b00);
    cycle(4'b0011, 1'b1);
    cycle(4'b0011, 1'b0);
    #1;
    check_eq("wrap_second", sel, 2'b01);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    cycle(4'b1000, 1'b0);
    #1;
    check_eq("skip_to_3", sel, 2'b11);

    // Owner drops its request mid-grant; grant must persist until done.
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    #1;
    check_eq("hold_no_req", en, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    // done pulses while idle are ignored.
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    #1;
    check_eq("idle_done_busy", busy, 1'b0);

    // Reset mid-grant, then first grant goes to lowest requester from 0.
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    async_reset();
    cycle(4'b1010, 1'b0);
    #1;
    check_eq("post_rst_grant", sel, 2'b01);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);

`ifdef SEL_TIMEOUT_EN
    // Forced release after HOLD cycles, then done on the last cycle.
    cycle(4'b0001, 1'b0);
    for (int i = 0; i < HOLD; i++) cycle(4'b0000, 1'b0);
    #1;
    check_eq("to_pulse", timeout, 1'b1);
    cycle(4'b0001, 1'b0);
    for (int i = 0; i < HOLD - 1; i++) cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b1);
    #1;
    check_eq("to_done_wins", timeout, 1'b0);
    cycle(4'b0000, 1'b0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(4'($urandom_range(15)), ($urandom_range(3) == 0));
    end
    @(negedge clk);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
